// File: rtl/aes_sub_bytes_pipe.sv
// Pipelined AES SubBytes/InvSubBytes over LANES bytes per beat, mode chosen per beat.
// Latency PIPE_STAGES cycles; valid/ready with full throughput, in_ready falls only when every stage is full and stalled.
module aes_sub_bytes_pipe #(
  parameter int LANES       = 16,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [8*LANES-1:0]   in_data,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_inv,
  output logic                 busy
);

  localparam int LAST = PIPE_STAGES - 1;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); also maps 0 to 0 without a special case
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sub_byte(input logic [7:0] b, input logic inv);
    logic [7:0] x;
    logic [7:0] y;
    if (inv) x = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    else     x = b;
    y = gf_inv(x);
    if (inv) return y;
    return y ^ {y[6:0], y[7]} ^ {y[5:0], y[7:6]} ^ {y[4:0], y[7:5]} ^ {y[3:0], y[7:4]} ^ 8'h63;
  endfunction

  logic [8*LANES-1:0]     sub_data;
  logic [PIPE_STAGES-1:0] v;
  logic [PIPE_STAGES-1:0] adv;
  logic [PIPE_STAGES-1:0] inv_q;
  logic [8*LANES-1:0]     data_q [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_q  [PIPE_STAGES];
  logic                   full_tail;

  always_comb begin
    sub_data = '0;
    for (int i = 0; i < LANES; i++) begin
      sub_data[8*i +: 8] = sub_byte(in_data[8*i +: 8], in_inv);
    end
  end

  // Stage k may advance unless it and every stage after it are full while out_ready is low.
  always_comb begin
    full_tail = 1'b1;
    adv       = '0;
    for (int k = LAST; k >= 0; k--) begin
      full_tail = full_tail & v[k];
      adv[k]    = !full_tail || out_ready;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v     <= '0;
      inv_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        data_q[k] <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= sub_data;
          tag_q[0]  <= in_tag;
          inv_q[0]  <= in_inv;
        end
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (adv[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            data_q[k] <= data_q[k-1];
            tag_q[k]  <= tag_q[k-1];
            inv_q[k]  <= inv_q[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[LAST];
  assign out_data  = data_q[LAST];
  assign out_tag   = tag_q[LAST];
  assign out_inv   = inv_q[LAST];
  assign busy      = |v;

endmodule

// File: tb/tb_aes_sub_bytes_pipe.sv
// Directed and table-driven bench for aes_sub_bytes_pipe: a 16-lane instance and a 1-lane instance
// for the full byte sweep, checked against a brute-force S-box model built at time zero.
module tb_aes_sub_bytes_pipe;
  localparam int P   = 2;
  localparam int L   = 16;
  localparam int TW  = 4;
  localparam int TW1 = 10;

  logic clk;
  logic rst;
  logic in_valid, in_ready, in_inv, out_valid, out_ready, out_inv, busy;
  logic [8*L-1:0] in_data, out_data;
  logic [TW-1:0]  in_tag, out_tag;

  logic in_valid1, in_ready1, in_inv1, out_valid1, out_ready1, out_inv1, busy1;
  logic [7:0]     in_data1, out_data1;
  logic [TW1-1:0] in_tag1, out_tag1;

  aes_sub_bytes_pipe #(.LANES(L), .PIPE_STAGES(P), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .out_inv(out_inv), .busy(busy));

  aes_sub_bytes_pipe #(.LANES(1), .PIPE_STAGES(P), .TAG_W(TW1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_inv(in_inv1),
    .in_data(in_data1), .in_tag(in_tag1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_tag(out_tag1), .out_inv(out_inv1), .busy(busy1));

  typedef struct { logic inv; logic [127:0] din; logic [127:0] dout; } vec_t;
  typedef struct { logic [127:0] d; logic [3:0] t; logic i; } exp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mon_cnt = 0;
  int acc = 0;
  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];
  exp_t exp_q [$];
  exp_t mon_e;
  vec_t vecs [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Carry-less product then reduction by 0x11b
  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_beat(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < L; i++) r[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_cnt++;
      chk("beat_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("out_data", out_data, mon_e.d);
        chk("out_tag", 128'(out_tag), 128'(mon_e.t));
        chk("out_inv", 128'(out_inv), 128'(mon_e.i));
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [3:0] t, input logic i,
                      input logic [127:0] ed, output int tin);
    exp_t e;
    int n;
    in_valid = 1'b1; in_data = d; in_tag = t; in_inv = i;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", 128'(in_ready), 128'(1));
    tin = cyc;
    if (in_ready) begin
      e.d = ed; e.t = t; e.i = i;
      exp_q.push_back(e);
      acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_lat(input int tin);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 128'(cyc - tin), 128'(P));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int tin, m0, n;
    logic [127:0] hold_d, d;
    logic [3:0] hold_t;
    logic got_hold, drv_done, t5_done;

    vecs[0] = '{1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
    vecs[1] = '{1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 128'h193de3bea0f4e22b9ac68d2ae9f84808};
    vecs[2] = '{1'b0, {16{8'h00}}, {16{8'h63}}};
    vecs[3] = '{1'b0, {16{8'h53}}, {16{8'hed}}};
    vecs[4] = '{1'b1, {16{8'h00}}, {16{8'h52}}};
    vecs[5] = '{1'b1, {16{8'h63}}, {16{8'h00}}};
    vecs[6] = '{1'b0, {4{32'h000153ff}}, {4{32'h637ced16}}};
    vecs[7] = '{1'b1, {4{32'h637ced16}}, {4{32'h000153ff}}};

    for (int x = 0; x < 256; x++) begin
      logic [7:0] xi, s, bx;
      bx = 8'(x);
      xi = 8'h00;
      if (x != 0) for (int y = 1; y < 256; y++) if (tb_mul(bx, 8'(y)) == 8'h01) xi = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = xi[b] ^ xi[(b+4)%8] ^ xi[(b+5)%8] ^ xi[(b+6)%8] ^ xi[(b+7)%8] ^ (8'h63 >> b) & 1'b1;
      fwd_t[x] = s;
      inv_t[s] = bx;
    end

    rst = 1'b1;
    in_valid = 0; in_inv = 0; in_data = '0; in_tag = '0; out_ready = 1'b1;
    in_valid1 = 0; in_inv1 = 0; in_data1 = '0; in_tag1 = '0; out_ready1 = 1'b1;
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_out_tag", 128'(out_tag), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_release", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // Hand-computed vectors, one beat at a time with latency check
    for (int k = 0; k < 8; k++) begin
      send(vecs[k].din, 4'(k), vecs[k].inv, vecs[k].dout, tin);
      wait_lat(tin);
      drain();
    end

    // 256 bytes forward then their images inverse, back-to-back on the 1-lane instance
    fork
      begin
        for (int j = 0; j < 512; j++) begin
          in_valid1 = 1'b1;
          in_inv1   = (j >= 256);
          in_data1  = (j < 256) ? 8'(j) : fwd_t[j-256];
          in_tag1   = 10'(j);
          @(posedge clk); #1;
        end
        in_valid1 = 1'b0;
      end
      begin
        n = 0;
        while (!out_valid1 && n < 50) begin
          @(negedge clk);
          n++;
        end
        for (int j = 0; j < 512; j++) begin
          chk("sweep_valid", 128'(out_valid1), 128'(1));
          chk("sweep_in_ready", 128'(in_ready1), 128'(1));
          chk("sweep_data", 128'(out_data1), 128'((j < 256) ? fwd_t[j] : 8'(j - 256)));
          chk("sweep_tag", 128'(out_tag1), 128'(j));
          chk("sweep_inv", 128'(out_inv1), 128'(j >= 256));
          @(negedge clk);
        end
      end
    join
    @(negedge clk);
    chk("sweep_idle", 128'(busy1), 128'(0));
    @(posedge clk); #1;

    // Backpressure: tags 1..8 with out_ready low for 5 cycles
    out_ready = 1'b0;
    m0 = mon_cnt;
    n = acc;
    drv_done = 1'b0;
    got_hold = 1'b0;
    fork
      begin
        int dummy;
        logic [7:0] b;
        for (int t = 1; t <= 8; t++) begin
          b = 8'(t * 17);
          send({16{b}}, 4'(t), 1'b0, ref_beat({16{b}}, 1'b0), dummy);
        end
        drv_done = 1'b1;
      end
    join_none
    repeat (5) begin
      @(negedge clk);
      if (out_valid) begin
        if (!got_hold) begin
          hold_d = out_data; hold_t = out_tag; got_hold = 1'b1;
        end else begin
          chk("stall_data_stable", out_data, hold_d);
          chk("stall_tag_stable", 128'(out_tag), 128'(hold_t));
        end
      end
    end
    chk("bp_accepted", 128'(acc - n), 128'(P));
    chk("bp_in_ready_low", 128'(in_ready), 128'(0));
    chk("bp_head_tag", 128'(out_tag), 128'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    while (!drv_done && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("bp_driver_done", 128'(drv_done), 128'(1));
    drain();
    chk("bp_beats_out", 128'(mon_cnt - m0), 128'(8));

    // Alternating modes under random backpressure
    t5_done = 1'b0;
    fork
      begin
        while (!t5_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    m0 = mon_cnt;
    for (int b = 0; b < 1000; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      send(d, 4'(b), b[0], ref_beat(d, b[0]), tin);
    end
    t5_done = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();
    chk("mix_beats_out", 128'(mon_cnt - m0), 128'(1000));

    // Reset with a full, stalled pipeline
    out_ready = 1'b0;
    for (int k = 0; k < P; k++) begin
      d = {16{8'(8'hA0 + k)}};
      send(d, 4'(12 + k), 1'(k), ref_beat(d, 1'(k)), tin);
    end
    @(negedge clk);
    chk("full_busy", 128'(busy), 128'(1));
    chk("full_in_ready", 128'(in_ready), 128'(0));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_out_data", out_data, 128'(0));
    chk("midrst_out_tag", 128'(out_tag), 128'(0));
    chk("midrst_out_inv", 128'(out_inv), 128'(0));
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 128'(in_ready), 128'(1));
    chk("postrst_out_valid", 128'(out_valid), 128'(0));
    m0 = mon_cnt;
    @(posedge clk); #1;
    send(vecs[0].din, 4'h9, 1'b0, vecs[0].dout, tin);
    wait_lat(tin);
    drain();
    repeat (4) @(negedge clk);
    chk("postrst_beats_out", 128'(mon_cnt - m0), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
